multi_line_window_buffer: RTL

//  Parametrised N-line pixel delay buffer for the Sobel pipeline; generalises the single-line FIFO.

---
 rtl/multi_line_window_buffer_pkg.sv | 20 ++
 rtl/multi_line_window_buffer_delay_line.sv | 44 ++++
 rtl/multi_line_window_buffer.sv | 112 +++++++++++
 3 files changed

// File: rtl/multi_line_window_buffer_pkg.sv
// Shared types and helpers for the multi-line window buffer: FSM state encoding and a
// width helper used to size pointers and counters.
package lb_pkg;

   typedef enum logic [0:0] {
      LB_FILL = 1'b0,
      LB_RUN  = 1'b1
   } lb_state_e;

   // Bits needed to hold values 0..value-1, never less than 1.
   function automatic int lb_clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/multi_line_window_buffer_delay_line.sv
// One line of pixel delay: circular RAM with a single pointer, read-before-write, so
// data_o is the pixel written exactly LINE_W accepted writes ago.
module lb_delay_line
   import lb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LINE_W = 640
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);

   localparam int              PTR_W    = lb_clog2(LINE_W);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_W - 1);

   logic [DATA_W-1:0] mem_q [LINE_W];
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  ptr_d;

   // Read side is the oldest entry; the top registers it, so the cascade stays aligned.
   assign data_o = mem_q[ptr_q];

   always_comb begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (we_i) begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/multi_line_window_buffer.sv
// N-line pixel delay buffer emitting one vertical column of NUM_LINES+1 taps per write.
// Optional LB_SOF_EN adds sof_i, restarting framing on a write with sof_i high.
module multi_line_window_buffer
   import lb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int LINE_W    = 640,
   parameter int NUM_LINES = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            we_i,
   input  logic [DATA_W-1:0]               data_i,
`ifdef LB_SOF_EN
   input  logic                            sof_i,
`endif
   output logic [(NUM_LINES+1)*DATA_W-1:0] taps_o,
   output logic                            valid_o,
   output logic                            eol_o,
   output logic [lb_clog2(LINE_W)-1:0]     col_o,
   output logic                            fill_done_o
);

   localparam int               COL_W     = lb_clog2(LINE_W);
   localparam int               FILL_N    = NUM_LINES * LINE_W;
   localparam int               FILL_W    = lb_clog2(FILL_N + 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_W - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FILL_N);

   logic [NUM_LINES:0][DATA_W-1:0] chain;
   logic [NUM_LINES:0][DATA_W-1:0] taps_q, taps_d;
   logic                           valid_q, valid_d;
   logic                           eol_q, eol_d;
   logic [COL_W-1:0]               col_q, col_d;
   logic [COL_W-1:0]               col_out_q, col_out_d;
   logic [FILL_W-1:0]              fill_q, fill_d;
   lb_state_e                      state_q, state_d;
   logic                           sof_w;
   logic [COL_W-1:0]               wr_col;
   logic [FILL_W-1:0]              wr_fill;

`ifdef LB_SOF_EN
   assign sof_w = we_i & sof_i;
`else
   assign sof_w = 1'b0;
`endif

   assign chain[0] = data_i;

   // Line pointers are not re-phased on sof: a delay of LINE_W writes does not depend on
   // where the pointer sits, and valid_o stays low until every tap holds post-sof data.
   for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      lb_delay_line #(
         .DATA_W (DATA_W),
         .LINE_W (LINE_W)
      ) u_line (
         .clk    (clk),
         .rst    (rst),
         .we_i   (we_i),
         .data_i (chain[gi]),
         .data_o (chain[gi+1])
      );
   end

   always_comb begin
      taps_d    = taps_q;
      valid_d   = 1'b0;
      eol_d     = 1'b0;
      col_d     = col_q;
      col_out_d = col_out_q;
      fill_d    = fill_q;
      state_d   = state_q;
      wr_col    = sof_w ? '0 : col_q;
      wr_fill   = sof_w ? '0 : fill_q;
      if (we_i) begin
         taps_d    = chain;
         col_out_d = wr_col;
         eol_d     = (wr_col == COL_LAST);
         col_d     = (wr_col == COL_LAST) ? '0 : wr_col + COL_W'(1);
         valid_d   = (wr_fill == FILL_FULL);
         fill_d    = (wr_fill == FILL_FULL) ? wr_fill : wr_fill + FILL_W'(1);
         state_d   = (fill_d == FILL_FULL) ? LB_RUN : LB_FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         taps_q    <= '0;
         valid_q   <= 1'b0;
         eol_q     <= 1'b0;
         col_q     <= '0;
         col_out_q <= '0;
         fill_q    <= '0;
         state_q   <= LB_FILL;
      end else begin
         taps_q    <= taps_d;
         valid_q   <= valid_d;
         eol_q     <= eol_d;
         col_q     <= col_d;
         col_out_q <= col_out_d;
         fill_q    <= fill_d;
         state_q   <= state_d;
      end
   end

   assign taps_o      = taps_q;
   assign valid_o     = valid_q;
   assign eol_o       = eol_q;
   assign col_o       = col_out_q;
   assign fill_done_o = (state_q == LB_RUN);

endmodule
